// File: rtl/alu_ctrl_md_pkg.sv
// rtl/alu_ctrl_md_pkg.sv - shared constants and types for the ALU-control decoder and md unit
package alu_ctrl_md_pkg;

    // ALU control codes driven onto alu_ct
    localparam logic [3:0] CT_NONE = 4'b0000;
    localparam logic [3:0] CT_ADD  = 4'b0010;
    localparam logic [3:0] CT_SUB  = 4'b0110;
    localparam logic [3:0] CT_AND  = 4'b1000;
    localparam logic [3:0] CT_OR   = 4'b1001;
    localparam logic [3:0] CT_SLT  = 4'b1011;
    localparam logic [3:0] CT_JR   = 4'b1010;

    // Op classes presented by main control on alu_ct_op
    localparam logic [4:0] OPC_ADD   = 5'b00000;
    localparam logic [4:0] OPC_SUB   = 5'b01000;
    localparam logic [4:0] OPC_AND   = 5'b00100;
    localparam logic [4:0] OPC_OR    = 5'b00010;
    localparam logic [4:0] OPC_SLT   = 5'b10001;
    localparam logic [4:0] OPC_RTYPE = 5'b10000;

    // R-type funct codes the decoder and md unit care about
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    // md unit sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Operation requested at the start of an md sequence
    typedef enum logic [1:0] {
        MD_MULU = 2'd0,
        MD_DIVU = 2'd1,
        MD_MULS = 2'd2,
        MD_DIVS = 2'd3
    } md_op_e;

    function automatic logic md_op_is_div(input md_op_e op);
        return (op == MD_DIVU) || (op == MD_DIVS);
    endfunction

endpackage

// File: rtl/alu_ctrl_md_md_iter_core.sv
// rtl/alu_ctrl_md_md_iter_core.sv - iterative shift-add multiply / restoring divide with HI/LO (ALU_CTRL_MD_SIGNED_EN adds signed ops)
module md_iter_core
    import alu_ctrl_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Mul: {partial sum, remaining multiplier}. Div: {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    // Multiplicand for mul, divisor for div (magnitudes)
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;

`ifdef ALU_CTRL_MD_SIGNED_EN
    logic is_signed;
    assign is_signed = (op == MD_MULS) || (op == MD_DIVS);
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;
`else
    assign a_neg     = 1'b0;
    assign b_neg     = 1'b0;
    assign a_mag     = a;
    assign b_mag     = b;
`endif

    // One shift-add step: conditionally add multiplicand to the upper half, then shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // One restoring step: shift next dividend bit into remainder, subtract if it fits
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
    assign div_ok    = ~div_diff[WIDTH+1];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        prod_q[WIDTH-2:0], div_ok};

    // Sign correction applied only on the final iteration
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign mul_fix = neg_res_q ? (~mul_next + 1'b1) : mul_next;
    assign quo_fix = neg_res_q ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];
    assign rem_fix = neg_rem_q ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1)
                               : div_next[2*WIDTH-1:WIDTH];

    // Next-state for the sequencer, datapath, HI/LO and the registered busy/done outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start && !flush) begin
                    if (md_op_is_div(op) && (b == '0)) begin
                        // Divide by zero completes immediately without iterating
                        hi_d   = a;
                        lo_d   = '1;
                        done_d = 1'b1;
                    end else begin
                        state_d   = md_op_is_div(op) ? ST_DIV : ST_MUL;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        prod_d    = {{WIDTH{1'b0}}, a_mag};
                        mcand_d   = b_mag;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end else if (!flush) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    prod_d = mul_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        {hi_d, lo_d} = mul_fix;
                    end
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    prod_d = div_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_ctrl_md.sv
// rtl/alu_ctrl_md.sv - ALU-control decoder with HI/LO multiply/divide unit and stall handshake (ALU_CTRL_MD_SIGNED_EN adds MULT/DIV)
module alu_ctrl_md
    import alu_ctrl_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5,
    parameter int CT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  alu_ct_op,
    input  logic [5:0]       funct,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [CT_W-1:0]  alu_ct,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_result,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    logic       is_rtype;
    logic [3:0] ct;

    assign is_rtype = (alu_ct_op == OP_W'(OPC_RTYPE));

    // Map op class / funct onto the ALU control code; unknown classes give CT_NONE
    always_comb begin
        ct = CT_NONE;
        if (alu_ct_op == OP_W'(OPC_ADD))       ct = CT_ADD;
        else if (alu_ct_op == OP_W'(OPC_SUB))  ct = CT_SUB;
        else if (alu_ct_op == OP_W'(OPC_AND))  ct = CT_AND;
        else if (alu_ct_op == OP_W'(OPC_OR))   ct = CT_OR;
        else if (alu_ct_op == OP_W'(OPC_SLT))  ct = CT_SLT;
        else if (is_rtype) begin
            if (funct == FN_JR) ct = CT_JR;
            else                ct = CT_ADD;
        end
    end

    assign alu_ct = CT_W'(ct);

    logic f_multu, f_divu, f_mult, f_div, f_mfhi, f_mthi, f_mflo, f_mtlo;
    assign f_multu = is_rtype && (funct == FN_MULTU);
    assign f_divu  = is_rtype && (funct == FN_DIVU);
    assign f_mfhi  = is_rtype && (funct == FN_MFHI);
    assign f_mthi  = is_rtype && (funct == FN_MTHI);
    assign f_mflo  = is_rtype && (funct == FN_MFLO);
    assign f_mtlo  = is_rtype && (funct == FN_MTLO);
`ifdef ALU_CTRL_MD_SIGNED_EN
    assign f_mult  = is_rtype && (funct == FN_MULT);
    assign f_div   = is_rtype && (funct == FN_DIV);
`else
    assign f_mult  = 1'b0;
    assign f_div   = 1'b0;
`endif

    logic md_any, md_start, accept;
    assign md_any   = f_multu | f_divu | f_mult | f_div | f_mfhi | f_mthi | f_mflo | f_mtlo;
    // Any md instruction waits for the unit; the one issued on the done cycle goes through
    assign accept   = valid_in & ~flush & ~busy;
    assign md_start = accept & (f_multu | f_divu | f_mult | f_div);

    md_op_e md_op;

    // Select which md operation a start launches
    always_comb begin
        md_op = MD_MULU;
        if (f_divu)      md_op = MD_DIVU;
        else if (f_mult) md_op = MD_MULS;
        else if (f_div)  md_op = MD_DIVS;
    end

    logic [WIDTH-1:0] hi, lo;

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (md_op),
        .a     (src_a),
        .b     (src_b),
        .flush (flush),
        .hi_we (accept & f_mthi),
        .lo_we (accept & f_mtlo),
        .wdata (src_a),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // HI/LO are written on the final iteration's edge, so reads on the done cycle see new values
    assign md_result = (funct == FN_MFHI) ? hi : lo;
    assign md_sel    = valid_in & (f_mfhi | f_mflo);
    assign stall     = busy & valid_in & md_any;

endmodule
